adder_share_arbiter: RTL and testbench

- Shares one pipelined_adder instance (W-bit operands, S pipeline stages, fixed latency, no stall) between N requesters using round-robin arbitration.
- A requester ID tag travels in a shadow pipeline next to the adder, so each sum returns only to the requester that issued it.
- Sits between the operand sources (LFSR checkers, test generators) and the shared adder. Also flags any loss of alignment between the adder's valid output and the tag pipeline.

---
 rtl/adder_share_pkg.sv | 27 ++
 rtl/adder_share_arbiter_rr_arbiter.sv | 63 ++++++
 rtl/adder_share_arbiter.sv | 105 ++++++++++
 tb/tb_adder_share_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared types for the adder-sharing arbiter: ID width helper and the tag that
// travels beside the adder pipeline.
`timescale 1ns/1ps
package adder_share_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Tags are sized for the largest supported requester count so one type serves every N.
    localparam int N_MAX = 16;
    localparam int IDW   = (clog2(N_MAX) < 1) ? 1 : clog2(N_MAX);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched cyclically from a
// registered pointer that moves just past each winner.
`timescale 1ns/1ps
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    input  logic [N-1:0]   i_req,
    output logic [N-1:0]   o_gnt,
    output logic           o_gnt_any,
    output logic [IDW-1:0] o_gnt_id
);

    logic [IDW-1:0] r_ptr;
    logic [N-1:0]   w_rot;
    logic           w_found;
    logic [IDW-1:0] w_off;
    logic [IDW:0]   w_wrap;
    logic [IDW-1:0] w_next;

    // Rotating a doubled copy puts the requester at the pointer on bit 0.
    assign w_rot = N'({i_req, i_req} >> r_ptr);

    always_comb begin
        // NOTE: every variable written here gets a default first; a path that leaves one unassigned would infer a latch.
        w_found = 1'b0;
        w_off   = '0;
        if (i_en) begin
            for (int k = 0; k < N; k++) begin
                if (!w_found && w_rot[k]) begin
                    w_found = 1'b1;
                    w_off   = IDW'(k);
                end
            end
        end
    end

    assign w_wrap    = {1'b0, r_ptr} + {1'b0, w_off};
    assign o_gnt_id  = (w_wrap >= (IDW+1)'(N)) ? IDW'(w_wrap - (IDW+1)'(N)) : w_wrap[IDW-1:0];
    assign o_gnt_any = w_found;
    assign w_next    = (o_gnt_id == IDW'(N-1)) ? '0 : o_gnt_id + 1'b1;

    always_comb begin
        o_gnt = '0;
        for (int j = 0; j < N; j++) begin
            o_gnt[j] = w_found && (o_gnt_id == IDW'(j));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_next;
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one fixed-latency pipelined adder among N requesters; a shadow tag
// pipeline routes each sum back to its issuer and flags valid/tag misalignment.
`timescale 1ns/1ps
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int W = 128,
    parameter int S = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    input  logic [N-1:0]   i_req,
    input  logic [N*W-1:0] i_op_a,
    input  logic [N*W-1:0] i_op_b,
    output logic [N-1:0]   o_gnt,
    output logic [N-1:0]   o_resp_valid,
    output logic [W-1:0]   o_resp_sum,
    output logic [W-1:0]   o_add_op1,
    output logic [W-1:0]   o_add_op2,
    output logic           o_add_valid_in,
    input  logic [W-1:0]   i_add_res,
    input  logic           i_add_valid_out,
    output logic           o_busy,
    output logic           o_error
);

    logic           w_gnt_any;
    logic [IDW-1:0] w_gnt_id;
    logic [W-1:0]   r_add_op1;
    logic [W-1:0]   r_add_op2;
    tag_t           r_issue;
    tag_t           r_tag [S];
    logic           r_error;

    rr_arbiter #(.N(N)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_en      (i_en),
        .i_req     (i_req),
        .o_gnt     (o_gnt),
        .o_gnt_any (w_gnt_any),
        .o_gnt_id  (w_gnt_id)
    );

    // The issue register tags the operation on the adder inputs; S stages behind it line up with add_valid_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_add_op1 <= '0;
            r_add_op2 <= '0;
            r_issue   <= '0;
        end else begin
            r_issue.valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_issue.id <= w_gnt_id;
                r_add_op1  <= i_op_a[int'(w_gnt_id)*W +: W];
                r_add_op2  <= i_op_b[int'(w_gnt_id)*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this array is reset on purpose; unlike a data buffer, a stale valid bit here would surface as a spurious response.
            for (int k = 0; k < S; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= r_issue;
            for (int k = 1; k < S; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (i_add_valid_out != r_tag[S-1].valid) begin
            r_error <= 1'b1;
        end
    end

    always_comb begin
        o_resp_valid = '0;
        for (int i = 0; i < N; i++) begin
            o_resp_valid[i] = i_add_valid_out && r_tag[S-1].valid && (r_tag[S-1].id == IDW'(i));
        end
    end

    always_comb begin
        o_busy = r_issue.valid;
        for (int k = 0; k < S; k++) begin
            o_busy = o_busy | r_tag[k].valid;
        end
    end

    assign o_resp_sum     = i_add_res;
    assign o_add_op1      = r_add_op1;
    assign o_add_op2      = r_add_op2;
    assign o_add_valid_in = r_issue.valid;
    assign o_error        = r_error;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a local S-stage adder model and a
// ring scoreboard of expected responses.
`timescale 1ns/1ps
module tb_adder_share_arbiter;

    localparam int W = 128;
    localparam int S = 4;
    localparam int N = 4;
    localparam int LAT = S + 1;

    logic           clk;
    logic           rst;
    logic           en;
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic [N-1:0]   gnt;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_sum;
    logic [W-1:0]   add_op1;
    logic [W-1:0]   add_op2;
    logic           add_valid_in;
    logic [W-1:0]   add_res;
    logic           add_valid_out;
    logic           busy;
    logic           error;
    logic           force_v;

    logic [S-1:0]   m_v;
    logic [W-1:0]   m_s [S];

    int n_chk;
    int n_fail;
    int cyc;
    int mp;
    int n_resp;
    logic           exp_err;
    logic [N-1:0]   exp_v [8];
    logic [W-1:0]   exp_s [8];

    adder_share_arbiter #(.W(W), .S(S), .N(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_en            (en),
        .i_req           (req),
        .i_op_a          (op_a),
        .i_op_b          (op_b),
        .o_gnt           (gnt),
        .o_resp_valid    (resp_valid),
        .o_resp_sum      (resp_sum),
        .o_add_op1       (add_op1),
        .o_add_op2       (add_op2),
        .o_add_valid_in  (add_valid_in),
        .i_add_res       (add_res),
        .i_add_valid_out (add_valid_out),
        .o_busy          (busy),
        .o_error         (error)
    );

    // Shared adder model: S register stages, sharing the arbiter's reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v <= '0;
            for (int k = 0; k < S; k++) m_s[k] <= '0;
        end else begin
            m_v    <= {m_v[S-2:0], add_valid_in};
            m_s[0] <= add_op1 + add_op2;
            for (int k = 1; k < S; k++) m_s[k] <= m_s[k-1];
        end
    end

    assign add_valid_out = m_v[S-1] | force_v;
    assign add_res       = m_s[S-1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_model();
        mp      = 0;
        exp_err = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_v[k] = '0;
            exp_s[k] = '0;
        end
    endtask

    // One clock cycle, entered shortly after a falling edge: check outputs, drive, check grant.
    task automatic step(input logic [N-1:0] req_v, input logic en_v);
        int           slot;
        int           g;
        logic         exp_busy;
        logic [N-1:0] eg;
        slot     = cyc % 8;
        exp_busy = 1'b0;
        for (int d = 0; d < LAT; d++) exp_busy = exp_busy | (exp_v[(cyc + d) % 8] != '0);
        check("resp_valid", W'(resp_valid), W'(exp_v[slot]));
        if (exp_v[slot] != '0) check("resp_sum", resp_sum, exp_s[slot]);
        check("busy", W'(busy), W'(exp_busy));
        check("error", W'(error), W'(exp_err));
        if (resp_valid != '0) n_resp++;
        exp_v[slot] = '0;

        req = req_v;
        en  = en_v;
        #1;
        g  = -1;
        eg = '0;
        if (en_v) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_v[(mp + k) % N]) g = (mp + k) % N;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        check("gnt", W'(gnt), W'(eg));
        if (g >= 0) begin
            exp_v[(cyc + LAT) % 8] = eg;
            exp_s[(cyc + LAT) % 8] = op_a[g*W +: W] + op_b[g*W +: W];
            mp = (g + 1) % N;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int r0;
        logic [W-1:0] x;
        n_chk   = 0;
        n_fail  = 0;
        cyc     = 0;
        n_resp  = 0;
        rst     = 1'b1;
        en      = 1'b0;
        req     = '0;
        op_a    = '0;
        op_b    = '0;
        force_v = 1'b0;
        clear_model();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_add_valid_in", W'(add_valid_in), W'(0));
        check("rst_add_op1", add_op1, W'(0));
        check("rst_add_op2", add_op2, W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_error", W'(error), W'(0));
        check("rst_resp_valid", W'(resp_valid), W'(0));
        check("rst_gnt", W'(gnt), W'(0));
        rst = 1'b0;

        // Single requester 2: 5 + 7 returns to requester 2 five cycles later
        op_a[2*W +: W] = W'(5);
        op_b[2*W +: W] = W'(7);
        step(4'b0100, 1'b1);
        check("single_op1", add_op1, W'(5));
        check("single_op2", add_op2, W'(7));
        repeat (3) step(4'b0000, 1'b1);
        check("single_pre_resp", W'(resp_valid), W'(0));
        step(4'b0000, 1'b1);
        check("single_resp_valid", W'(resp_valid), W'(4'b0100));
        check("single_resp_sum", resp_sum, W'(12));
        repeat (2) step(4'b0000, 1'b1);
        check("single_busy_after", W'(busy), W'(0));

        // All four continuously from pointer 0, including wrap-around
        rst = 1'b1;
        #1;
        rst = 1'b0;
        clear_model();
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < N; i++) begin
                op_a[i*W +: W] = W'(100 * (i + 1) + k);
                op_b[i*W +: W] = W'(3 * k + i);
            end
            step(4'b1111, 1'b1);
        end
        repeat (LAT + 1) step(4'b0000, 1'b1);

        // Complementary operands: every sum must be all-ones
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < N; i++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                op_a[i*W +: W] = x;
                op_b[i*W +: W] = ~x;
            end
            if (resp_valid != '0) check("lfsr_all_ones", resp_sum, {W{1'b1}});
            step(4'b1111, 1'b1);
        end
        repeat (LAT + 1) step(4'b0000, 1'b1);
        check("lfsr_error_clear", W'(error), W'(0));

        // en dropped after two accepts while requests stay high
        r0 = n_resp;
        for (int i = 0; i < N; i++) begin
            op_a[i*W +: W] = W'(i + 1);
            op_b[i*W +: W] = W'(16 * (i + 1));
        end
        repeat (2) step(4'b1111, 1'b1);
        repeat (LAT + 3) step(4'b1111, 1'b0);
        check("en_drop_resp_count", W'(n_resp - r0), W'(2));
        check("en_drop_busy_low", W'(busy), W'(0));

        // Asynchronous reset mid-cycle with three operations in flight
        repeat (3) step(4'b1111, 1'b1);
        check("pre_rst_busy", W'(busy), W'(1));
        req = '0;
        en  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_add_valid_in", W'(add_valid_in), W'(0));
        check("arst_add_op1", add_op1, W'(0));
        check("arst_add_op2", add_op2, W'(0));
        check("arst_busy", W'(busy), W'(0));
        check("arst_resp_valid", W'(resp_valid), W'(0));
        check("arst_add_valid_out", W'(add_valid_out), W'(0));
        check("arst_gnt", W'(gnt), W'(0));
        rst = 1'b0;
        clear_model();
        repeat (LAT + 2) step(4'b0000, 1'b1);
        step(4'b1111, 1'b1);
        repeat (LAT + 1) step(4'b0000, 1'b1);

        // Forced add_valid_out with an empty tag pipeline sets sticky error
        force_v = 1'b1;
        #1;
        check("misalign_resp_valid", W'(resp_valid), W'(0));
        step(4'b0000, 1'b0);
        force_v = 1'b0;
        exp_err = 1'b1;
        repeat (3) step(4'b0000, 1'b0);
        step(4'b1111, 1'b1);
        repeat (LAT + 1) step(4'b0000, 1'b1);
        check("error_sticky", W'(error), W'(1));
        rst = 1'b1;
        #1;
        check("error_cleared_by_rst", W'(error), W'(0));
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
